// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the RAM request controller.
// Holds the controller FSM state type, timing helpers derived from the RAM
// pipeline configuration, and the even-parity function that the RAM and the
// controller agree on.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  // Widest data word the parity helper accepts; narrower words are zero-extended,
  // which does not change their parity.
  localparam int PAR_MAX_W = 64;

  // Number of cycles a strobe/address must be held for the RAM to capture it.
  function automatic int hold_cycles(input int addr_pipe);
    return 1 + addr_pipe;
  endfunction

  // Cycle (counting the first strobe cycle as 1) whose closing edge samples dout.
  function automatic int read_latency(input int addr_pipe, input int dout_pipe);
    return hold_cycles(addr_pipe) + dout_pipe + 1;
  endfunction

  // Even parity: XOR of all data bits.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_parity_chk.sv
// Combinational parity check of a RAM read word against its parity bit.
// Ports:
//   i_data   - RAM read data
//   i_parity - parity bit delivered by the RAM
//   o_err    - 1 when the recomputed parity differs from i_parity
module mem_parity_chk
  import mem_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] i_data,
  input  logic         i_parity,
  output logic         o_err
);

  logic [PAR_MAX_W-1:0] w_data_ext;

  assign w_data_ext = PAR_MAX_W'(i_data);
  assign o_err      = even_parity(w_data_ext) != i_parity;

endmodule

// File: rtl/mem_req_ctrl.sv
// Initiator-side controller for the single-port parity RAM.
// Turns a valid/ready request stream into RAM write/read accesses timed for the
// configured address/output pipelining, returns read data with a parity flag,
// and keeps a saturating parity error count.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   req_valid/ready/write/addr/wdata - request channel (one outstanding)
//   rsp_valid/ready/rdata/perr  - read response channel
//   mem_*                       - RAM pin interface (all outputs registered)
//   err_cnt                     - saturating parity error counter
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADD_SIZE  = 10,
  parameter int MEM_WIDTH = 16,
  parameter int ADDR_PIPE = 0,
  parameter int DOUT_PIPE = 0,
  parameter int ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADD_SIZE-1:0]  req_addr,
  input  logic [MEM_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MEM_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_perr,
  output logic [MEM_WIDTH-1:0] mem_din,
  output logic [ADD_SIZE-1:0]  mem_addr,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic                 mem_blk_sel,
  output logic                 mem_addr_en,
  output logic                 mem_dout_en,
  input  logic [MEM_WIDTH-1:0] mem_dout,
  input  logic                 mem_parity_out,
  output logic [ERR_W-1:0]     err_cnt
);

  localparam int HOLD  = hold_cycles(ADDR_PIPE);
  localparam int K     = read_latency(ADDR_PIPE, DOUT_PIPE);
  localparam int CNT_W = $clog2(K + 1);

  // Counter reload values: the phase ends when the counter reaches zero.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(DOUT_PIPE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic [MEM_WIDTH-1:0] r_rsp_rdata;
  logic                 r_rsp_perr;
  logic [ERR_W-1:0]     r_err_cnt;
  logic [MEM_WIDTH-1:0] r_mem_din;
  logic [ADD_SIZE-1:0]  r_mem_addr;
  logic                 r_mem_wr_en;
  logic                 r_mem_rd_en;
  logic                 r_mem_blk_sel;
  logic                 w_perr;

  mem_parity_chk #(
    .W (MEM_WIDTH)
  ) u_parity_chk (
    .i_data   (mem_dout),
    .i_parity (mem_parity_out),
    .o_err    (w_perr)
  );

  // Request FSM with registered RAM strobes and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_perr    <= 1'b0;
      r_err_cnt     <= '0;
      r_mem_din     <= '0;
      r_mem_addr    <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_blk_sel <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            // Capture the request; later input changes are ignored.
            r_req_ready   <= 1'b0;
            r_mem_addr    <= req_addr;
            r_mem_blk_sel <= 1'b1;
            r_cnt         <= HOLD_LOAD;
            if (req_write) begin
              r_state     <= WR;
              r_mem_wr_en <= 1'b1;
              r_mem_din   <= req_wdata;
            end else begin
              r_state     <= RD;
              r_mem_rd_en <= 1'b1;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WR: begin
          if (r_cnt == '0) begin
            r_state       <= IDLE;
            r_mem_wr_en   <= 1'b0;
            r_mem_blk_sel <= 1'b0;
            r_req_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        RD: begin
          if (r_cnt == '0) begin
            r_state       <= WAIT;
            r_mem_rd_en   <= 1'b0;
            r_mem_blk_sel <= 1'b0;
            r_cnt         <= WAIT_LOAD;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        WAIT: begin
          // Zero count marks the edge where RAM output is valid.
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= mem_dout;
            r_rsp_perr  <= w_perr;
            if (w_perr && (r_err_cnt != ERR_MAX)) begin
              r_err_cnt <= r_err_cnt + ERR_ONE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_req_ready   <= 1'b0;
          r_rsp_valid   <= 1'b0;
          r_mem_wr_en   <= 1'b0;
          r_mem_rd_en   <= 1'b0;
          r_mem_blk_sel <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_perr    = r_rsp_perr;
  assign err_cnt     = r_err_cnt;
  assign mem_din     = r_mem_din;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_blk_sel = r_mem_blk_sel;
  assign mem_addr_en = (ADDR_PIPE != 0);
  assign mem_dout_en = (DOUT_PIPE != 0);

endmodule
